// File: rtl/receptor_serial.sv
// Serial-to-parallel receiver: hunts for SYNC, then assembles PALABRAS words of WIDTH bits (MSB- or LSB-first).
// Words appear the cycle after their last bit; a word completing while q is still held (valido=1, listo=0) is dropped and desborde sticks.
module receptor_serial #(
  parameter int                WIDTH    = 4,
  parameter logic [WIDTH-1:0]  SYNC     = 4'b1010,
  parameter int                PALABRAS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             s_in,
  input  logic             dir,
  input  logic             listo,
  output logic [WIDTH-1:0] q,
  output logic             valido,
  output logic             sincronizado,
  output logic             desborde
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (PALABRAS > 1) ? $clog2(PALABRAS) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [PW-1:0] LAST_WORD = PW'(PALABRAS - 1);

  typedef enum logic {BUSCAR, CAPTURA} state_t;

  state_t           state;
  logic [WIDTH-1:0] window;
  logic [WIDTH-1:0] acc;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    word_cnt;
  logic             dir_lat;

  logic [WIDTH-1:0] window_next;
  logic [WIDTH-1:0] acc_next;
  logic             word_done;
  logic             out_free;

  always_comb begin
    window_next = {window[WIDTH-2:0], s_in};
    acc_next    = dir_lat ? {s_in, acc[WIDTH-1:1]} : {acc[WIDTH-2:0], s_in};
    word_done   = enb && (state == CAPTURA) && (bit_cnt == LAST_BIT);
    // The register counts as free when its current word leaves on this same edge.
    out_free    = !valido || listo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BUSCAR;
      window       <= '0;
      acc          <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      dir_lat      <= 1'b0;
      q            <= '0;
      valido       <= 1'b0;
      sincronizado <= 1'b0;
      desborde     <= 1'b0;
    end else begin
      case (state)
        BUSCAR: begin
          if (enb) begin
            window <= window_next;
            if (window_next == SYNC) begin
              state        <= CAPTURA;
              sincronizado <= 1'b1;
              dir_lat      <= dir;
              bit_cnt      <= '0;
              word_cnt     <= '0;
            end
          end
        end
        CAPTURA: begin
          if (enb) begin
            acc <= acc_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              // Window restarts from zero so resync needs WIDTH fresh bits.
              if (word_cnt == LAST_WORD) begin
                state        <= BUSCAR;
                sincronizado <= 1'b0;
                window       <= '0;
                word_cnt     <= '0;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= BUSCAR;
      endcase

      if (word_done && out_free) begin
        q      <= acc_next;
        valido <= 1'b1;
      end else begin
        if (word_done)
          desborde <= 1'b1;
        if (valido && listo)
          valido <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receptor_serial.sv
// Bench for receptor_serial: directed frames plus random traffic against a bit-queue reference model.
module tb_receptor_serial;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enb = 1'b0;
  logic       s_in = 1'b0;
  logic       dir = 1'b0;
  logic       listo = 1'b0;
  logic [3:0] q;
  logic       valido;
  logic       sincronizado;
  logic       desborde;

  int errors = 0;
  int checks = 0;

  receptor_serial #(.WIDTH(4), .SYNC(4'b1010), .PALABRAS(2)) dut (
    .clk(clk), .reset(reset), .enb(enb), .s_in(s_in), .dir(dir), .listo(listo),
    .q(q), .valido(valido), .sincronizado(sincronizado), .desborde(desborde)
  );

  always #5 clk = ~clk;

  // Reference model: sliding window value, captured bits of the current word, words taken so far.
  int         m_hist;
  bit         m_cap;
  bit         m_dir;
  bit         bitq[$];
  int         m_words;
  logic [3:0] m_q;
  bit         m_vld;
  bit         m_ovf;

  // Words seen by the consumer, one entry per new presentation on q.
  logic [3:0] seen[$];
  bit         prev_vld;

  function automatic void model_step(input bit r, input bit e, input bit s, input bit d, input bit l);
    bit got;
    bit free;
    int w;
    got = 0;
    w   = 0;
    if (r) begin
      m_hist = 0; m_cap = 0; m_dir = 0; bitq.delete(); m_words = 0;
      m_q = 4'd0; m_vld = 0; m_ovf = 0;
      return;
    end
    free = !m_vld || l;
    if (e) begin
      if (!m_cap) begin
        m_hist = (m_hist * 2 + int'(s)) % 16;
        if (m_hist == 10) begin
          m_cap = 1; m_dir = d; bitq.delete(); m_words = 0;
        end
      end else begin
        bitq.push_back(s);
        if (bitq.size() == 4) begin
          for (int i = 0; i < 4; i++)
            w = m_dir ? w + (int'(bitq[i]) << i) : w * 2 + int'(bitq[i]);
          bitq.delete();
          got = 1;
          m_words++;
          if (m_words == 2) begin
            m_cap = 0; m_hist = 0;
          end
        end
      end
    end
    if (got && free) begin
      m_q = w[3:0]; m_vld = 1;
    end else begin
      if (got) m_ovf = 1;
      if (m_vld && l) m_vld = 0;
    end
  endfunction

  task automatic tick(input bit r, input bit e, input bit s, input bit d, input bit l);
    reset = r; enb = e; s_in = s; dir = d; listo = l;
    @(posedge clk);
    model_step(r, e, s, d, l);
    #1;
    if (valido === 1'b1 && (!prev_vld || l)) seen.push_back(q);
    prev_vld = (valido === 1'b1);
  endtask

  task automatic test_reset;
    logic [3:0] pat;
    pat = 4'b1010;
    for (int i = 0; i < 2; i++)
      tick(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    for (int i = 3; i >= 0; i--)
      tick(1, 1, pat[i], 0, 1);
    checks++;
    if ({q, valido, sincronizado, desborde} !== 7'b0000_000) begin
      errors++;
      $display("FAIL reset_state: got q=%b vld=%b sync=%b ovf=%b, want all zero", q, valido, sincronizado, desborde);
    end
    tick(0, 0, 0, 0, 1);
    checks++;
    if (sincronizado !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_sync: got sync=%b want 0", sincronizado);
    end
  endtask

  task automatic test_msb_frame;
    logic [11:0] bits;
    int vld_cycles;
    bits = 12'b1010_0110_1100;
    vld_cycles = 0;
    seen.delete();
    for (int i = 11; i >= 0; i--) begin
      tick(0, 1, bits[i], 0, 1);
      checks++;
      if ({q, valido, sincronizado, desborde} !== {m_q, m_vld, m_cap, m_ovf}) begin
        errors++;
        $display("FAIL msb_cycle: got q=%b v=%b s=%b o=%b want q=%b v=%b s=%b o=%b",
                 q, valido, sincronizado, desborde, m_q, m_vld, m_cap, m_ovf);
      end
      if (valido) vld_cycles++;
      if (i == 8) begin
        checks++;
        if (sincronizado !== 1'b1) begin
          errors++; $display("FAIL msb_sync_rise: got %b want 1", sincronizado);
        end
      end
    end
    checks++;
    if (sincronizado !== 1'b0) begin
      errors++; $display("FAIL msb_sync_fall: got %b want 0", sincronizado);
    end
    tick(0, 0, 0, 0, 1);
    if (valido) vld_cycles++;
    tick(0, 0, 0, 0, 1);
    checks++;
    if (seen.size() != 2 || seen[0] !== 4'b0110 || seen[1] !== 4'b1100 || vld_cycles != 2) begin
      errors++;
      $display("FAIL msb_words: got n=%0d w0=%b w1=%b vcycles=%0d want n=2 0110 1100 vcycles=2",
               seen.size(), seen.size() > 0 ? seen[0] : 4'hx, seen.size() > 1 ? seen[1] : 4'hx, vld_cycles);
    end
  endtask

  task automatic test_lsb_false_start;
    logic [12:0] bits;
    bits = 13'b11010_1100_0111;
    seen.delete();
    for (int i = 12; i >= 0; i--) begin
      tick(0, 1, bits[i], 1, 1);
      checks++;
      if ({q, valido, sincronizado, desborde} !== {m_q, m_vld, m_cap, m_ovf}) begin
        errors++;
        $display("FAIL lsb_cycle: got q=%b v=%b s=%b o=%b want q=%b v=%b s=%b o=%b",
                 q, valido, sincronizado, desborde, m_q, m_vld, m_cap, m_ovf);
      end
      if (i == 9 || i == 8) begin
        checks++;
        if (sincronizado !== (i == 8)) begin
          errors++; $display("FAIL lsb_sync_at_bit5: bit %0d got sync=%b", 13 - i, sincronizado);
        end
      end
    end
    tick(0, 0, 0, 1, 1);
    checks++;
    if (seen.size() != 2 || seen[0] !== 4'b0011 || seen[1] !== 4'b1110) begin
      errors++;
      $display("FAIL lsb_words: got n=%0d w0=%b w1=%b want 0011 1110",
               seen.size(), seen.size() > 0 ? seen[0] : 4'hx, seen.size() > 1 ? seen[1] : 4'hx);
    end
  endtask

  task automatic test_backpressure;
    logic [11:0] bits;
    bits = 12'b1010_0110_1100;
    for (int i = 11; i >= 0; i--) begin
      tick(0, 1, bits[i], 0, 0);
      checks++;
      if ({q, valido, sincronizado, desborde} !== {m_q, m_vld, m_cap, m_ovf}) begin
        errors++;
        $display("FAIL bp_cycle: got q=%b v=%b s=%b o=%b want q=%b v=%b s=%b o=%b",
                 q, valido, sincronizado, desborde, m_q, m_vld, m_cap, m_ovf);
      end
    end
    checks++;
    if ({q, valido, desborde} !== {4'b0110, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL bp_hold_drop: got q=%b v=%b o=%b want q=0110 v=1 o=1", q, valido, desborde);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    checks++;
    if ({valido, desborde} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got v=%b o=%b want v=0 o=1", valido, desborde);
    end
  endtask

  task automatic test_gaps_resync;
    logic [11:0] f1;
    logic [11:0] f2;
    f1 = 12'b1010_0110_1100;
    f2 = 12'b1010_1010_0001;
    tick(1, 0, 0, 0, 1);
    seen.delete();
    for (int i = 11; i >= 0; i--) begin
      tick(0, 1, f1[i], 0, 1);
      if (i == 4 || i == 0) begin
        checks++;
        if ({valido, q} !== {1'b1, (i == 4) ? 4'b0110 : 4'b1100}) begin
          errors++;
          $display("FAIL gap_word_latency: bit %0d got v=%b q=%b", 12 - i, valido, q);
        end
      end
      for (int g = 0; g < 3; g++) begin
        tick(0, 0, $urandom_range(0, 1), 0, 1);
        checks++;
        if ({q, valido, sincronizado, desborde} !== {m_q, m_vld, m_cap, m_ovf}) begin
          errors++;
          $display("FAIL gap_cycle: got q=%b v=%b s=%b o=%b want q=%b v=%b s=%b o=%b",
                   q, valido, sincronizado, desborde, m_q, m_vld, m_cap, m_ovf);
        end
      end
    end
    for (int i = 11; i >= 0; i--) begin
      tick(0, 1, f2[i], 0, 1);
      checks++;
      if ({q, valido, sincronizado, desborde} !== {m_q, m_vld, m_cap, m_ovf}) begin
        errors++;
        $display("FAIL resync_cycle: got q=%b v=%b s=%b o=%b want q=%b v=%b s=%b o=%b",
                 q, valido, sincronizado, desborde, m_q, m_vld, m_cap, m_ovf);
      end
    end
    tick(0, 0, 0, 0, 1);
    checks++;
    if (seen.size() != 4 || seen[0] !== 4'b0110 || seen[1] !== 4'b1100 ||
        seen[2] !== 4'b1010 || seen[3] !== 4'b0001) begin
      errors++;
      $display("FAIL gap_resync_words: got n=%0d last=%b want 0110 1100 1010 0001",
               seen.size(), seen.size() > 0 ? seen[seen.size()-1] : 4'hx);
    end
  endtask

  task automatic test_reset_midframe;
    logic [5:0]  part;
    logic [11:0] full;
    part = 6'b1010_01;
    full = 12'b1010_0110_1100;
    seen.delete();
    for (int i = 5; i >= 0; i--) tick(0, 1, part[i], 0, 1);
    tick(1, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 1);
      checks++;
      if ({sincronizado, valido} !== 2'b00) begin
        errors++; $display("FAIL midreset_idle: got sync=%b v=%b want 0 0", sincronizado, valido);
      end
    end
    for (int i = 11; i >= 0; i--) tick(0, 1, full[i], 0, 1);
    tick(0, 0, 0, 0, 1);
    checks++;
    if (seen.size() != 2 || seen[0] !== 4'b0110 || seen[1] !== 4'b1100) begin
      errors++;
      $display("FAIL midreset_words: got n=%0d w0=%b w1=%b want 0110 1100",
               seen.size(), seen.size() > 0 ? seen[0] : 4'hx, seen.size() > 1 ? seen[1] : 4'hx);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 2) != 0);
      checks++;
      if ({q, valido, sincronizado, desborde} !== {m_q, m_vld, m_cap, m_ovf}) begin
        errors++;
        $display("FAIL random_cycle %0d: got q=%b v=%b s=%b o=%b want q=%b v=%b s=%b o=%b",
                 n, q, valido, sincronizado, desborde, m_q, m_vld, m_cap, m_ovf);
      end
    end
  endtask

  initial begin
    m_hist = 0; m_cap = 0; m_dir = 0; m_words = 0;
    m_q = 4'd0; m_vld = 0; m_ovf = 0; prev_vld = 0;
    #1;
    test_reset();
    test_msb_frame();
    test_lsb_false_start();
    test_backpressure();
    test_gaps_resync();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
